// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: ALU result capture, overflow traps, HALT, forwarding.
// Optional OVF_TRAP_EN macro adds precise overflow traps and the TRAP state.
module ex_mem_latch #(
   parameter int WORD_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [WORD_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic              alu_neg,
   input  logic              alu_ovf,
   input  logic              ex_trapop,
   input  logic [WORD_W-1:0] ex_pc,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwen,
   input  logic              ex_memren,
   input  logic              ex_memwen,
   input  logic [WORD_W-1:0] ex_sdata,
   input  logic              ex_halt,
   input  logic              exc_ack,
   output logic              mem_valid,
   output logic [WORD_W-1:0] mem_result,
   output logic              mem_zero,
   output logic              mem_neg,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_regwen,
   output logic              mem_memren,
   output logic              mem_memwen,
   output logic [WORD_W-1:0] mem_sdata,
   output logic              fwd_valid,
   output logic              exc_valid,
   output logic [WORD_W-1:0] epc,
   output logic              halted
);

`ifdef OVF_TRAP_EN
   typedef enum logic [1:0] {S_RUN, S_TRAP, S_HALTED} state_t;
`else
   typedef enum logic [1:0] {S_RUN, S_HALTED} state_t;
`endif

   state_t r_state;
   state_t w_state_nxt;

   logic              r_valid;
   logic [WORD_W-1:0] r_result;
   logic              r_zero;
   logic              r_neg;
   logic [REG_AW-1:0] r_rd;
   logic              r_regwen;
   logic              r_memren;
   logic              r_memwen;
   logic [WORD_W-1:0] r_sdata;

   logic w_live;
   logic w_cap;
   logic w_trap;
   logic w_halt;

`ifdef OVF_TRAP_EN
   logic [WORD_W-1:0] r_epc;

   // An acknowledge lets this very edge capture as if already in RUN.
   assign w_live = (r_state == S_RUN) ||
                   ((r_state == S_TRAP) && exc_ack);
   assign w_cap  = w_live && en && !flush;
   assign w_trap = w_cap && ex_valid && ex_trapop && alu_ovf;
`else
   logic w_unused;

   assign w_unused = &{1'b0, alu_ovf, ex_trapop, exc_ack, ex_pc};
   assign w_live   = (r_state == S_RUN);
   assign w_cap    = w_live && en && !flush;
   assign w_trap   = 1'b0;
`endif

   assign w_halt = w_cap && ex_valid && ex_halt && !w_trap;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_RUN: begin
            if (w_trap)
               w_state_nxt = S_TRAP_OR_RUN();
            else if (w_halt)
               w_state_nxt = S_HALTED;
         end
`ifdef OVF_TRAP_EN
         S_TRAP: begin
            if (exc_ack) begin
               if (w_trap)
                  w_state_nxt = S_TRAP;
               else if (w_halt)
                  w_state_nxt = S_HALTED;
               else
                  w_state_nxt = S_RUN;
            end
         end
`endif
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   function automatic state_t S_TRAP_OR_RUN();
`ifdef OVF_TRAP_EN
      return S_TRAP;
`else
      return S_RUN;
`endif
   endfunction

   always_ff @(posedge CLK) begin
      if (RST)
         r_state <= S_RUN;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_rd     <= '0;
         r_regwen <= 1'b0;
         r_memren <= 1'b0;
         r_memwen <= 1'b0;
         r_sdata  <= '0;
      end else if (flush || !w_live) begin
         r_valid  <= 1'b0;
         r_regwen <= 1'b0;
         r_memren <= 1'b0;
         r_memwen <= 1'b0;
      end else if (en) begin
         // A trapping op stays valid in MEM but loses all side effects.
         r_valid  <= ex_valid;
         r_result <= alu_out;
         r_zero   <= alu_zero;
         r_neg    <= alu_neg;
         r_rd     <= ex_rd;
         r_regwen <= ex_valid && ex_regwen && !w_trap;
         r_memren <= ex_valid && ex_memren && !w_trap;
         r_memwen <= ex_valid && ex_memwen && !w_trap;
         r_sdata  <= ex_sdata;
      end
   end

`ifdef OVF_TRAP_EN
   always_ff @(posedge CLK) begin
      if (RST)
         r_epc <= '0;
      else if (w_trap)
         r_epc <= ex_pc;
   end

   assign exc_valid = (r_state == S_TRAP);
   assign epc       = r_epc;
`else
   assign exc_valid = 1'b0;
   assign epc       = '0;
`endif

   assign halted     = (r_state == S_HALTED);
   assign mem_valid  = r_valid;
   assign mem_result = r_result;
   assign mem_zero   = r_zero;
   assign mem_neg    = r_neg;
   assign mem_rd     = r_rd;
   assign mem_regwen = r_regwen;
   assign mem_memren = r_memren;
   assign mem_memwen = r_memwen;
   assign mem_sdata  = r_sdata;
   assign fwd_valid  = r_valid && r_regwen && (r_rd != '0);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch; trap cases run only with OVF_TRAP_EN.
module tb_ex_mem_latch;

   logic        CLK = 1'b0;
   logic        RST;
   logic        en, flush, ex_valid;
   logic [31:0] alu_out;
   logic        alu_zero, alu_neg, alu_ovf, ex_trapop;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_regwen, ex_memren, ex_memwen;
   logic [31:0] ex_sdata;
   logic        ex_halt, exc_ack;
   logic        mem_valid;
   logic [31:0] mem_result;
   logic        mem_zero, mem_neg;
   logic [4:0]  mem_rd;
   logic        mem_regwen, mem_memren, mem_memwen;
   logic [31:0] mem_sdata;
   logic        fwd_valid, exc_valid;
   logic [31:0] epc;
   logic        halted;

   always #5 CLK = ~CLK;

   ex_mem_latch dut (
      .CLK(CLK), .RST(RST), .en(en), .flush(flush),
      .ex_valid(ex_valid), .alu_out(alu_out),
      .alu_zero(alu_zero), .alu_neg(alu_neg),
      .alu_ovf(alu_ovf), .ex_trapop(ex_trapop),
      .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_regwen(ex_regwen), .ex_memren(ex_memren),
      .ex_memwen(ex_memwen), .ex_sdata(ex_sdata),
      .ex_halt(ex_halt), .exc_ack(exc_ack),
      .mem_valid(mem_valid), .mem_result(mem_result),
      .mem_zero(mem_zero), .mem_neg(mem_neg),
      .mem_rd(mem_rd), .mem_regwen(mem_regwen),
      .mem_memren(mem_memren), .mem_memwen(mem_memwen),
      .mem_sdata(mem_sdata), .fwd_valid(fwd_valid),
      .exc_valid(exc_valid), .epc(epc), .halted(halted)
   );

   typedef struct {
      logic        v;
      logic [31:0] res;
      logic        rw, mr, mw;
      logic [4:0]  rd;
      logic        exc;
      logic        hlt;
      logic        cres;
      logic [31:0] epc;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] e_epc   = '0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb(input logic v, input logic [31:0] res,
                     input logic rw, input logic mr, input logic mw,
                     input logic [4:0] rd, input logic exc,
                     input logic hlt, input logic cres);
      exp_t e;
      e.v = v; e.res = res; e.rw = rw; e.mr = mr; e.mw = mw;
      e.rd = rd; e.exc = exc; e.hlt = hlt; e.cres = cres;
      e.epc = e_epc;
      q.push_back(e);
   endtask

   task automatic tick(input string tag);
      exp_t e;
      @(posedge CLK);
      #1;
      if (q.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check({tag, ".valid"},  {31'd0, mem_valid},  {31'd0, e.v});
         check({tag, ".regwen"}, {31'd0, mem_regwen}, {31'd0, e.rw});
         check({tag, ".memren"}, {31'd0, mem_memren}, {31'd0, e.mr});
         check({tag, ".memwen"}, {31'd0, mem_memwen}, {31'd0, e.mw});
         check({tag, ".fwd"},    {31'd0, fwd_valid},
               {31'd0, e.v & e.rw & (e.rd != 5'd0)});
         check({tag, ".exc"},    {31'd0, exc_valid},  {31'd0, e.exc});
         check({tag, ".halted"}, {31'd0, halted},     {31'd0, e.hlt});
         check({tag, ".epc"},    epc, e.epc);
         if (e.cres) begin
            check({tag, ".result"}, mem_result, e.res);
            check({tag, ".rd"},     {27'd0, mem_rd}, {27'd0, e.rd});
         end
      end
   endtask

   task automatic idle();
      RST = 0; en = 1; flush = 0; ex_valid = 0;
      alu_out = '0; alu_zero = 0; alu_neg = 0; alu_ovf = 0;
      ex_trapop = 0; ex_pc = '0; ex_rd = '0; ex_regwen = 0;
      ex_memren = 0; ex_memwen = 0; ex_sdata = '0;
      ex_halt = 0; exc_ack = 0;
   endtask

   task automatic op(input logic [31:0] res, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic mw);
      idle();
      ex_valid = 1; alu_out = res; ex_rd = rd;
      ex_regwen = rw; ex_memren = mr; ex_memwen = mw;
   endtask

   initial begin
      idle();
      RST = 1; en = 1; flush = 1; ex_valid = 1;
      alu_out = '1; alu_zero = 1; alu_neg = 1; alu_ovf = 1;
      ex_trapop = 1; ex_pc = '1; ex_rd = '1; ex_regwen = 1;
      ex_memren = 1; ex_memwen = 1; ex_sdata = '1;
      ex_halt = 1; exc_ack = 1;
      sb(0, 0, 0, 0, 0, 0, 0, 0, 1); tick("rst0");
      sb(0, 0, 0, 0, 0, 0, 0, 0, 1); tick("rst1");

      idle();
      sb(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("idle");

      op(32'h10, 5'd5, 1, 0, 0);
      sb(1, 32'h10, 1, 0, 0, 5'd5, 0, 0, 1); tick("cap");
      for (int i = 0; i < 3; i++) begin
         op(32'hABC0 + i, 5'd6, 1, 1, 1);
         en = 0;
         sb(1, 32'h10, 1, 0, 0, 5'd5, 0, 0, 1); tick("hold");
      end

      op(32'h20, 5'd7, 0, 0, 1);
      flush = 1; en = 0;
      sb(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("flush_en0");

      op(32'h1234, 5'd0, 1, 1, 0);
      sb(1, 32'h1234, 1, 1, 0, 5'd0, 0, 0, 1); tick("rd0_nofwd");

      op(32'h8000_0000, 5'd3, 1, 0, 0);
      alu_ovf = 1; alu_neg = 1; ex_pc = 32'h3C;
      sb(1, 32'h8000_0000, 1, 0, 0, 5'd3, 0, 0, 1); tick("ovf_notrap");

`ifdef OVF_TRAP_EN
      op(32'h8000_0000, 5'd3, 1, 0, 0);
      alu_ovf = 1; ex_trapop = 1; ex_pc = 32'h40;
      e_epc = 32'h40;
      sb(1, 32'h8000_0000, 0, 0, 0, 5'd3, 1, 0, 1); tick("trap");
      for (int i = 0; i < 2; i++) begin
         op(32'h99, 5'd9, 1, 0, 1);
         ex_pc = 32'h44;
         sb(0, 0, 0, 0, 0, 0, 1, 0, 0); tick("trap_bubble");
      end
      op(32'h77, 5'd7, 1, 0, 0);
      exc_ack = 1;
      sb(1, 32'h77, 1, 0, 0, 5'd7, 0, 0, 1); tick("ack");
      op(32'h78, 5'd8, 1, 0, 0);
      exc_ack = 1;
      sb(1, 32'h78, 1, 0, 0, 5'd8, 0, 0, 1); tick("ack_in_run");

      op(32'h8000_0000, 5'd3, 1, 0, 0);
      alu_ovf = 1; ex_trapop = 1; ex_pc = 32'h80;
      e_epc = 32'h80;
      sb(1, 32'h8000_0000, 0, 0, 0, 5'd3, 1, 0, 1); tick("trap2");
      op(32'h8000_0000, 5'd4, 1, 0, 0);
      alu_ovf = 1; ex_trapop = 1; ex_pc = 32'hC0; exc_ack = 1;
      e_epc = 32'hC0;
      sb(1, 32'h8000_0000, 0, 0, 0, 5'd4, 1, 0, 1); tick("ack_retrap");
      idle();
      exc_ack = 1;
      sb(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("ack_idle");

      op(32'h8000_0000, 5'd2, 1, 0, 0);
      alu_ovf = 1; ex_trapop = 1; ex_halt = 1; ex_pc = 32'hD0;
      e_epc = 32'hD0;
      sb(1, 32'h8000_0000, 0, 0, 0, 5'd2, 1, 0, 1); tick("trap_halt");
      idle();
      exc_ack = 1;
      sb(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("ack_after_th");
`else
      op(32'h8000_0000, 5'd3, 1, 0, 0);
      alu_ovf = 1; ex_trapop = 1; ex_pc = 32'h40; exc_ack = 1;
      sb(1, 32'h8000_0000, 1, 0, 0, 5'd3, 0, 0, 1); tick("ovf_addu");
`endif

      op(32'h0, 5'd0, 0, 0, 0);
      ex_halt = 1;
      sb(1, 32'h0, 0, 0, 0, 5'd0, 0, 1, 1); tick("halt");
      for (int i = 0; i < 2; i++) begin
         op(32'h100 + i, 5'd1, 0, 0, 1);
         sb(0, 0, 0, 0, 0, 0, 0, 1, 0); tick("halted_store");
      end
      op(32'h200, 5'd1, 1, 0, 0);
      en = 0;
      sb(0, 0, 0, 0, 0, 0, 0, 1, 0); tick("halted_en0");

      idle();
      RST = 1;
      e_epc = '0;
      sb(0, 0, 0, 0, 0, 0, 0, 0, 1); tick("rst_clear");
      op(32'h55, 5'd10, 1, 0, 1);
      sb(1, 32'h55, 1, 0, 1, 5'd10, 0, 0, 1); tick("after_rst");

      check("sb_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
